// File: rtl/bcd_seq_if.sv
// Start/busy/done handshake and result bus for the sequential binary-to-BCD converter.
interface bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      num;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, num, input busy, done, bcd);
  modport slave  (input start, num, output busy, done, bcd);
endinterface

// File: rtl/bcd_seq_converter.sv
// Multi-cycle double-dabble binary-to-BCD converter: one adjust/shift datapath
// reused for every operand bit, sequenced by a three-state FSM.
//
//   state  | meaning
//   IDLE   | waiting for start; bcd holds the last result
//   ADJUST | add 3 to every scratch digit >= 5
//   SHIFT  | shift {scr, bin_sr} left one bit; finish when the last bit is in
module bcd_seq_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  bcd_seq_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [BIN_W-1:0]        bin_sr, bin_sr_nxt;
  logic [SCR_W-1:0]        scr, scr_nxt, scr_adj;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    busy_q, busy_nxt;
  logic                    done_q, done_nxt;
  logic [SCR_W-1:0]        bcd_q, bcd_nxt;
  logic [SCR_W+BIN_W-1:0]  shifted;
  logic                    scr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_sr <= '0;
      scr    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      state  <= state_nxt;
      bin_sr <= bin_sr_nxt;
      scr    <= scr_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      bcd_q  <= bcd_nxt;
    end
  end

  // Per-digit add-3; the 4-bit add never carries because inputs are 5..9.
  always_comb begin
    scr_adj = scr;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr[4*k +: 4] >= 4'd5) begin
        scr_adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {scr, bin_sr} << 1;

  always_comb begin
    state_nxt  = state;
    bin_sr_nxt = bin_sr;
    scr_nxt    = scr;
    cnt_nxt    = cnt;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    bcd_nxt    = bcd_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bin_sr_nxt = bus.num;
          scr_nxt    = '0;
          cnt_nxt    = CNT_W'(BIN_W);
          busy_nxt   = 1'b1;
          state_nxt  = ADJUST;
        end
      end
      ADJUST: begin
        scr_nxt   = scr_adj;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        {scr_nxt, bin_sr_nxt} = shifted;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_nxt   = shifted[SCR_W+BIN_W-1:BIN_W];
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = ADJUST;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

  always_comb begin
    scr_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr[4*k +: 4] > 4'd9) scr_ok = 1'b0;
    end
  end

  // A digit above 9 after a shift means the add-3 step or DIGITS sizing is wrong.
  a_scr_digits: assert property (@(posedge clk) disable iff (!rst_n)
    (state == SHIFT) |=> scr_ok);
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: latency-based behavioural model compared
// every cycle, plus literal expectations for the listed operands.
module tb_bcd_seq_converter;
  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  bit   check_en = 1'b0;

  bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int n);
    logic [11:0] r;
    int          v;
    r = '0;
    v = n;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a conversion occupies 2*BIN_W edges after acceptance, then pulses done.
  int          m_rem  = 0;
  bit          m_done = 1'b0;
  logic [11:0] m_bcd  = '0;
  logic [7:0]  m_val  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_bcd  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (bus.start) begin
          m_rem <= 2 * BIN_W;
          m_val <= bus.num;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_bcd  <= ref_bcd(int'(m_val));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 32'(bus.busy), 32'(m_rem != 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("bcd", 32'(bus.bcd), 32'(m_bcd));
      for (int k = 0; k < DIGITS; k++) begin
        chk("digit_le9", 32'(bus.bcd[4*k +: 4] <= 4'd9), 32'd1);
      end
    end
  end

  // Waits (bounded) for done; n = negedge index after the accepting edge, nb = busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        return;
      end
      if (bus.busy) nb++;
    end
  endtask

  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int n, nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num   = v;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(n, nb);
    chk({tag, "_latency"}, 32'(n), 32'd17);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd16);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n, nb, dones;
    bus.start = 1'b0;
    bus.num   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;

    run_conv(8'd0,   12'h000, "zero");
    run_conv(8'd255, 12'h255, "max");
    run_conv(8'd99,  12'h099, "n99");
    run_conv(8'd100, 12'h100, "n100");

    // Start held high: 42 then 7, back to back.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num   = 8'd42;
    @(posedge clk);
    #1 bus.num = 8'd7;
    wait_done(n, nb);
    chk("held1_latency", 32'(n), 32'd17);
    chk("held1_bcd", 32'(bus.bcd), 32'h042);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(n, nb);
    chk("held2_period", 32'(n), 32'd17);
    chk("held2_bcd", 32'(bus.bcd), 32'h007);

    // Starts while busy are ignored; num changes after acceptance have no effect.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num   = 8'd60;
    @(posedge clk);
    #1 begin
      bus.start = 1'b0;
      bus.num   = 8'd77;
    end
    n = 0;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (n == 0) n = i;
      end
      bus.start = (i == 3 || i == 8 || i == 15);
      if (bus.start) bus.num = 8'd123;
    end
    bus.start = 1'b0;
    chk("ignore_latency", 32'(n), 32'd17);
    chk("ignore_dones", 32'(dones), 32'd1);
    chk("ignore_bcd", 32'(bus.bcd), 32'h060);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num   = 8'd200;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd", 32'(bus.bcd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_bcd_held", 32'(bus.bcd), 32'd0);
    run_conv(8'd200, 12'h200, "after_abort");

    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), ref_bcd(v), "sweep");
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
